// File: rtl/serial_rx_fifo.sv
// Receive-side first-word-fall-through FIFO behind the serial receiver, with
// edge-detected byte/error strobes, sticky status and a saturating error counter.
module serial_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_x,
    input  logic [7:0]            i_data,
    input  logic                  i_valid,
    input  logic                  i_error,
    input  logic                  i_ready,
    input  logic                  i_clear,
    output logic [7:0]            o_data,
    output logic                  o_valid,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_frame_error,
    output logic [7:0]            o_error_count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  v_d;
    logic                  e_d;

    logic push_ev;
    logic err_ev;
    logic full;
    logic pop;
    logic push_req;
    logic write;

    // An error edge claims the frame, so a valid edge in the same cycle is dropped.
    assign push_ev  = i_valid & ~v_d;
    assign err_ev   = i_error & ~e_d;
    assign full     = (count == FULL_COUNT);
    assign pop      = o_valid & i_ready & ~i_clear;
    assign push_req = push_ev & ~err_ev & ~i_clear;
    assign write    = push_req & (~full | pop);

    assign o_valid = (count != '0);
    assign o_count = count;
    assign o_data  = o_valid ? mem[rd_ptr] : 8'h00;

    // The edge registers keep tracking through a clear so a held level cannot re-fire.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            v_d <= 1'b0;
            e_d <= 1'b0;
        end else begin
            v_d <= i_valid;
            e_d <= i_error;
        end
    end

    // NOTE: storage has no reset; stale entries are never visible because o_data is gated by o_valid.
    always_ff @(posedge clk) begin
        if (write) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            o_overflow    <= 1'b0;
            o_frame_error <= 1'b0;
            o_error_count <= 8'h00;
        end else if (i_clear) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            o_overflow    <= 1'b0;
            o_frame_error <= 1'b0;
            o_error_count <= 8'h00;
        end else begin
            if (write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (write && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !write) begin
                count <= count - 1'b1;
            end
            if (push_req && full && !pop) begin
                o_overflow <= 1'b1;
            end
            if (err_ev) begin
                o_frame_error <= 1'b1;
                if (o_error_count != 8'hff) begin
                    o_error_count <= o_error_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/serial_rx_fifo.md
Name: serial_rx_fifo

Overview:
Receive-side buffer placed directly downstream of the serial receiver, in the same clk_x4 domain. It captures each received byte from the receiver's data/valid/error outputs into a first-word-fall-through FIFO. It offers a valid/ready read port to the consumer and keeps sticky overflow and framing-error status plus a saturating error counter.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (depth = 2**DEPTH_LOG2 = 16 entries)

Ports:
clk  in  1  single clock; same clock as the receiver's clk_x4
rst_x  in  1  asynchronous active-low reset
i_data  in  8  received byte from receiver o_data
i_valid  in  1  receiver o_valid; byte strobe
i_error  in  1  receiver o_error; missing stop bit indication
i_ready  in  1  consumer accepts o_data this cycle
i_clear  in  1  synchronous flush of FIFO contents and status
o_data  out  8  head-of-FIFO byte
o_valid  out  1  FIFO non-empty
o_count  out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2
o_overflow  out  1  sticky: a byte was dropped because the FIFO was full
o_frame_error  out  1  sticky: the receiver flagged an error
o_error_count  out  8  saturating count of receiver error events

Behaviour:
- Reset (rst_x low, asynchronous): read and write pointers = 0; count = 0; o_valid = 0; o_data = 0; o_overflow = 0; o_frame_error = 0; o_error_count = 0; edge registers = 0.
- Edge detection: i_valid and i_error are registered every cycle (v_d, e_d).
  - Push event = i_valid & ~v_d.
  - Error event = i_error & ~e_d.
  - A level held for many cycles therefore yields exactly one event; a 1-cycle pulse also yields one event.
- Push: on a push event, i_data is sampled in that same cycle and written at wr_ptr, and wr_ptr increments.
- Latency: byte written at edge n; o_valid = 1 and o_data = byte from edge n+1. o_data is registered, or read from memory with a registered pointer, and must be stable while o_valid = 1 and i_ready = 0.
- Pop: when o_valid & i_ready, rd_ptr increments and o_data shows the next entry in the following cycle.
- i_ready while empty is ignored.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth. Occupancy is tracked by a separate count register or by an extra pointer bit; full = count == 2**DEPTH_LOG2.
- Count update: push only → +1; pop only → −1; push and pop together → unchanged.
- Full:
  - Push without a simultaneous pop → byte dropped, pointers unchanged, o_overflow set to 1.
  - Push with a simultaneous pop → pop and push both performed, count stays full, no overflow.
- Empty: a push with no pop makes the FIFO non-empty next cycle. There is no same-cycle bypass to o_valid.
- Error event:
  - Sets o_frame_error to 1.
  - Increments o_error_count, saturating at 255.
  - Does not push a byte. The receiver's data on an error frame is discarded even if i_valid also rises.
  - Exception: the push is still taken if its valid edge occurs in a different cycle from the error edge.
- i_clear (synchronous) has priority over push, pop and error in the same cycle:
  - Pointers and count go to 0.
  - o_overflow, o_frame_error and o_error_count go to 0.
  - o_valid = 0 next cycle.
  - An event coinciding with i_clear is discarded. The edge registers still update, so a level held across the clear does not re-trigger.
- Reset asserted mid-operation drops all content immediately, with no completion of pending transfers.

Test Plan:
1. Reset, then push 0x4d and, 9 cycles later, 0xaa via 1-cycle i_valid pulses, with i_ready = 1 → o_valid rises one cycle after each push; o_data = 0x4d, then 0xaa; o_count returns to 0; both status flags stay 0.
2. Hold i_valid high for 5 cycles with i_data = 0x55 → exactly one entry (o_count = 1, o_data = 0x55); release and re-assert → second entry.
3. i_ready = 0; push 17 distinct bytes 0x00..0x10 → o_count = 16, o_overflow = 1; then drain with i_ready = 1 → reads 0x00..0x0f in order, 0x10 absent, o_valid = 0 after the 16th pop.
4. FIFO full, i_ready = 1, push 0x99 in the same cycle as a pop → o_count stays 16, o_overflow stays 0, 0x99 appears as the last drained byte.
5. Pulse i_error 3 times, then 300 times → o_frame_error = 1; o_error_count = 3, then saturates at 255. No FIFO entries are created.
6. With 4 entries stored and both flags set, assert i_clear together with a push edge → next cycle o_count = 0, o_valid = 0, all status 0, and the pushed byte is not stored. Also assert rst_x low mid-drain → all outputs 0 asynchronously.
